rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Shares the single regfile write port (wr_en/rd/wr_data) between NREQ writeback sources (ALU, LSU, MUL/DIV) using round-robin arbitration. It also keeps a per-register pending-write scoreboard. Decode reserves a destination register at issue and stalls on RAW/WAW hazards using the busy outputs. The block sits between the execute/writeback units and the regfile write port.

Parameters:
NREQ, 3, number of writeback requesters (2..4); index 0 has highest priority after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
issue_valid  in  1  decode wants to reserve issue_rd
issue_rd  in  5  destination register being issued
issue_ready  out  1  reservation accepted this cycle
chk_rs1  in  5  decode source 1 register index
chk_rs2  in  5  decode source 2 register index
rs1_busy  out  1  chk_rs1 has a pending write
rs2_busy  out  1  chk_rs2 has a pending write
req_valid  in  NREQ  writeback request per source
req_rd  in  5*NREQ  destination per source; source i at bits [5i+4:5i]
req_data  in  32*NREQ  data per source; source i at bits [32i+31:32i]
req_ready  out  NREQ  one-hot grant; the source's transfer completes this cycle
wr_en  out  1  regfile write enable
rd  out  5  regfile write address
wr_data  out  32  regfile write data
err  out  1  sticky flag: a write targeted a register that was not busy

Behaviour:
- State:
  - busy[31:1] scoreboard. busy[0] is hard-wired to 0.
  - rr_ptr, log2(NREQ) bits.
  - err.
- Reset (async, while rst=1):
  - busy=0, rr_ptr=0, err=0.
  - All combinational outputs forced low: req_ready=0, wr_en=0, rd=0, wr_data=0, issue_ready=0, rs1_busy=0, rs2_busy=0.
- Arbitration (combinational, zero latency):
  - Search for a valid source starting at rr_ptr, going upward with wrap modulo NREQ. The first valid source found is granted.
  - At most one req_ready bit is high per cycle. No request means no grant.
  - A source must hold req_valid, req_rd and req_data stable until it sees req_ready.
- Write port outputs:
  - With a grant g and req_rd[g]!=0: wr_en=1, rd=req_rd[g], wr_data=req_data[g].
  - With a grant to rd=0: req_ready still asserts, wr_en=0, and the data is discarded.
  - No grant: wr_en=0, rd=0, wr_data=0.
- Round-robin pointer: on a clock edge with a grant, rr_ptr becomes (g+1) mod NREQ. Without a grant, rr_ptr holds.
- Scoreboard outputs:
  - rs1_busy = busy[chk_rs1] and rs2_busy = busy[chk_rs2], read from registered state.
  - A register being written in the current cycle still reads busy. The regfile write lands at the same edge, so decode sees clean data from the next cycle.
- Issue handshake:
  - issue_ready = issue_valid && !busy[issue_rd]. This stalls on WAW.
  - issue_rd=0: issue_ready=1 and no reservation is made.
  - On issue_valid && issue_ready with issue_rd!=0, busy[issue_rd] is set at the edge.
- Clear: a granted write with req_rd!=0 clears busy[req_rd] at the edge.
- Simultaneous clear and set of the same register: set wins, so busy stays 1. This is the case of an old writer retiring while a new writer issues.
  - This is legal only because busy was 1 and issue_ready saw the old value. In practice issue_ready=0 in that cycle, so the collision cannot occur through the handshake.
- err:
  - Set on a granted write with req_rd!=0 and busy[req_rd]=0.
  - The write is still performed.
  - err clears only on rst.
- Reset mid-operation: all pending reservations are dropped. In-flight sources must be flushed externally.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> all outputs 0 immediately; after release busy=0, issue_valid with issue_rd=5 gives issue_ready=1, and rs1_busy=1 for chk_rs1=5 on the next cycle.
- Single writeback: reserve x5; source1 req_rd=5, data=0xDEADBEEF -> same cycle req_ready=3'b010, wr_en=1, rd=5, wr_data=0xDEADBEEF; next cycle busy[5]=0 and err=0.
- Round-robin fairness: reserve x1..x6; all three sources continuously valid -> grant order 0,1,2,0,1,2 over six cycles; no source is granted twice before the others.
- WAW stall: x7 busy, issue_rd=7 -> issue_ready=0. In the cycle x7 is written, issue_ready is still 0; the next cycle issue_ready=1 and busy[7] is set again.
- x0 handling: issue_rd=0 -> issue_ready=1 and busy unchanged. Write with req_rd=0, data=0x1234 -> req_ready=1, wr_en=0, err stays 0.
- Spurious write: req_rd=9 with busy[9]=0 -> wr_en=1, rd=9; err=1 from the next cycle and stays 1 until rst.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port, plus a per-register
// pending-write scoreboard used by decode for RAW/WAW stalls.
module rf_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  output logic              issue_ready,
  input  logic [4:0]        chk_rs1,
  input  logic [4:0]        chk_rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_rd,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              wr_en,
  output logic [4:0]        rd,
  output logic [31:0]       wr_data,
  output logic              err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [31:0]   busy_r;
  logic [31:0]   busy_nxt_s;
  logic [PW-1:0] rr_ptr_r;
  logic [PW-1:0] rr_nxt_s;
  logic [PW-1:0] grant_idx_s;
  logic          grant_found_s;
  logic [PW:0]   scan_s;
  logic [4:0]    src_rd_s   [NREQ];
  logic [31:0]   src_data_s [NREQ];
  logic [4:0]    g_rd_s;
  logic [31:0]   g_data_s;
  logic          wr_fire_s;
  logic          issue_fire_s;
  logic          err_r;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign src_rd_s[gi]   = req_rd[5*gi +: 5];
      assign src_data_s[gi] = req_data[32*gi +: 32];
    end
  endgenerate

  // Scan upward from rr_ptr with wrap; first valid source wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    scan_s        = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_s = {1'b0, rr_ptr_r} + (PW+1)'(k);
      if (scan_s >= (PW+1)'(NREQ)) begin
        scan_s = scan_s - (PW+1)'(NREQ);
      end else begin
        scan_s = scan_s;
      end
      if (!grant_found_s && req_valid[scan_s[PW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = scan_s[PW-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Granted source selection, pointer advance and handshake qualifiers.
  always_comb begin
    g_rd_s       = src_rd_s[grant_idx_s];
    g_data_s     = src_data_s[grant_idx_s];
    wr_fire_s    = grant_found_s && (g_rd_s != 5'd0);
    issue_fire_s = issue_valid && !busy_r[issue_rd] && (issue_rd != 5'd0);
    if (grant_idx_s == PW'(NREQ-1)) begin
      rr_nxt_s = '0;
    end else begin
      rr_nxt_s = grant_idx_s + PW'(1);
    end
  end

  // Scoreboard next state: a retiring write clears, a new issue sets (set wins).
  always_comb begin
    busy_nxt_s = busy_r;
    if (wr_fire_s) begin
      busy_nxt_s[g_rd_s] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (issue_fire_s) begin
      busy_nxt_s[issue_rd] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard, round-robin pointer and sticky error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r   <= 32'd0;
      rr_ptr_r <= '0;
      err_r    <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      if (grant_found_s) begin
        rr_ptr_r <= rr_nxt_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      // A write to a register nobody reserved is still performed, only flagged.
      if (wr_fire_s && !busy_r[g_rd_s]) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Zero-latency outputs, all held low while reset is asserted.
  always_comb begin
    req_ready   = '0;
    wr_en       = 1'b0;
    rd          = 5'd0;
    wr_data     = 32'd0;
    issue_ready = 1'b0;
    rs1_busy    = 1'b0;
    rs2_busy    = 1'b0;
    if (rst) begin
      req_ready = '0;
    end else begin
      issue_ready = issue_valid && !busy_r[issue_rd];
      rs1_busy    = busy_r[chk_rs1];
      rs2_busy    = busy_r[chk_rs2];
      if (grant_found_s) begin
        req_ready = NREQ'(1) << grant_idx_s;
        rd        = g_rd_s;
        wr_en     = wr_fire_s;
        wr_data   = wr_fire_s ? g_data_s : 32'd0;
      end else begin
        req_ready = '0;
      end
    end
  end

  assign err = err_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (NREQ=3).
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [4:0]  rd;
  logic [31:0] wr_data;
  logic        err;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  rf_wb_arbiter #(.NREQ(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .wr_en(wr_en), .rd(rd), .wr_data(wr_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [4:0] r, input logic [31:0] d);
    req_rd[5*i +: 5]    = r;
    req_data[32*i +: 32] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_req_ready"}, {29'd0, req_ready}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_rd"}, {27'd0, rd}, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_issue_ready"}, {31'd0, issue_ready}, 32'd0);
    chk({tag, "_rs1_busy"}, {31'd0, rs1_busy}, 32'd0);
    chk({tag, "_rs2_busy"}, {31'd0, rs2_busy}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  int          exp_g  [6] = '{2, 0, 1, 2, 0, 1};
  logic [4:0]  exp_rd [6] = '{5'd3, 5'd1, 5'd2, 5'd6, 5'd4, 5'd5};
  logic [4:0]  rr_rd  [3][2] = '{'{5'd1, 5'd4}, '{5'd2, 5'd5}, '{5'd3, 5'd6}};
  int          cnt    [3];

  initial begin
    rst = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd5;
    chk_rs1 = 5'd5; chk_rs2 = 5'd0;
    req_valid = 3'b001; req_rd = '0; req_data = '0;
    set_src(0, 5'd3, 32'hCAFE_0000);
    #2;
    chk_all_low("in_reset");
    issue_valid = 1'b0; req_valid = 3'b000;
    next_cycle();
    rst = 1'b0;

    // Reserve x5, then observe it busy.
    issue_valid = 1'b1; issue_rd = 5'd5; #1;
    chk("issue_x5_ready", {31'd0, issue_ready}, 32'd1);
    chk("x5_not_busy_yet", {31'd0, rs1_busy}, 32'd0);
    next_cycle();
    issue_valid = 1'b0; #1;
    chk("x5_busy", {31'd0, rs1_busy}, 32'd1);

    // Single writeback from source 1.
    req_valid = 3'b010; set_src(1, 5'd5, 32'hDEAD_BEEF); #1;
    chk("wb1_ready", {29'd0, req_ready}, 32'd2);
    chk("wb1_wr_en", {31'd0, wr_en}, 32'd1);
    chk("wb1_rd", {27'd0, rd}, 32'd5);
    chk("wb1_data", wr_data, 32'hDEAD_BEEF);
    chk("wb1_busy_same_cycle", {31'd0, rs1_busy}, 32'd1);
    next_cycle();
    req_valid = 3'b000; #1;
    chk("wb1_cleared", {31'd0, rs1_busy}, 32'd0);
    chk("wb1_err", {31'd0, err}, 32'd0);
    chk("idle_ready", {29'd0, req_ready}, 32'd0);
    chk("idle_wr_en", {31'd0, wr_en}, 32'd0);

    // Reserve x1..x6.
    for (int r = 1; r <= 6; r++) begin
      issue_valid = 1'b1; issue_rd = 5'(r); #1;
      chk("reserve_ready", {31'd0, issue_ready}, 32'd1);
      next_cycle();
    end
    issue_valid = 1'b0;

    // All sources valid; pointer sits at 2 after the source-1 grant.
    cnt = '{0, 0, 0};
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < 3; s++) set_src(s, rr_rd[s][cnt[s]], 32'h100 * (s + 1) + 32'(cnt[s]));
      #1;
      chk("rr_grant", {29'd0, req_ready}, 32'd1 << exp_g[c]);
      chk("rr_rd", {27'd0, rd}, {27'd0, exp_rd[c]});
      chk("rr_data", wr_data, 32'h100 * (exp_g[c] + 1) + 32'(cnt[exp_g[c]]));
      cnt[exp_g[c]]++;
      next_cycle();
    end
    req_valid = 3'b000;
    chk_rs1 = 5'd1; chk_rs2 = 5'd6; #1;
    chk("rr_x1_clear", {31'd0, rs1_busy}, 32'd0);
    chk("rr_x6_clear", {31'd0, rs2_busy}, 32'd0);
    chk("rr_err", {31'd0, err}, 32'd0);

    // WAW stall on x7.
    issue_valid = 1'b1; issue_rd = 5'd7; #1;
    chk("x7_reserve", {31'd0, issue_ready}, 32'd1);
    next_cycle();
    #1;
    chk("waw_stall", {31'd0, issue_ready}, 32'd0);
    next_cycle();
    req_valid = 3'b001; set_src(0, 5'd7, 32'h77); #1;
    chk("waw_wb_grant", {29'd0, req_ready}, 32'd1);
    chk("waw_wb_wr_en", {31'd0, wr_en}, 32'd1);
    chk("waw_still_stalled", {31'd0, issue_ready}, 32'd0);
    next_cycle();
    req_valid = 3'b000; #1;
    chk("waw_released", {31'd0, issue_ready}, 32'd1);
    next_cycle();
    issue_valid = 1'b0; chk_rs2 = 5'd7; #1;
    chk("x7_rebusy", {31'd0, rs2_busy}, 32'd1);

    // x0 issue and write; pointer now 1.
    issue_valid = 1'b1; issue_rd = 5'd0; #1;
    chk("x0_issue_ready", {31'd0, issue_ready}, 32'd1);
    next_cycle();
    issue_valid = 1'b0; chk_rs1 = 5'd0; #1;
    chk("x0_not_busy", {31'd0, rs1_busy}, 32'd0);
    chk("x7_unchanged", {31'd0, rs2_busy}, 32'd1);
    req_valid = 3'b010; set_src(1, 5'd0, 32'h1234); #1;
    chk("x0_wb_ready", {29'd0, req_ready}, 32'd2);
    chk("x0_wb_wr_en", {31'd0, wr_en}, 32'd0);
    next_cycle();
    req_valid = 3'b000; #1;
    chk("x0_wb_err", {31'd0, err}, 32'd0);

    // Spurious write to x9; pointer now 2.
    req_valid = 3'b100; set_src(2, 5'd9, 32'hABCD); #1;
    chk("spur_ready", {29'd0, req_ready}, 32'd4);
    chk("spur_wr_en", {31'd0, wr_en}, 32'd1);
    chk("spur_rd", {27'd0, rd}, 32'd9);
    chk("spur_err_before", {31'd0, err}, 32'd0);
    next_cycle();
    req_valid = 3'b000; #1;
    chk("spur_err_set", {31'd0, err}, 32'd1);
    next_cycle();
    next_cycle();
    chk("spur_err_sticky", {31'd0, err}, 32'd1);

    // Mid-cycle reset with activity pending.
    issue_valid = 1'b1; issue_rd = 5'd0; chk_rs1 = 5'd7; chk_rs2 = 5'd7;
    req_valid = 3'b111; set_src(0, 5'd3, 32'h1); set_src(1, 5'd4, 32'h2);
    #2;
    rst = 1'b1; #1;
    chk_all_low("mid_reset");
    next_cycle();
    rst = 1'b0; issue_valid = 1'b0; #1;
    chk("post_reset_x7_free", {31'd0, rs1_busy}, 32'd0);
    chk("post_reset_grant0", {29'd0, req_ready}, 32'd1);
    chk("post_reset_err", {31'd0, err}, 32'd0);
    req_valid = 3'b000;
    next_cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
